// File: rtl/servo_frame_shift_reg_if.sv
// Bus between the SPI byte receiver side (master: shift/commit) and the
// servo frame shift register (slave: committed taps and frame status).
//
// Handshake: there is no backpressure. shift and commit are single-cycle
// strobes sampled on every rising clk edge. commit_ok / commit_err answer a
// commit with a one-cycle pulse in the cycle after the commit edge.
// commit is re-evaluated on every cycle it is high; it is not edge-detected.
interface servo_frame_shift_reg_if #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int NUM_TAPS = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       shift;
  logic [DATA_W-1:0]          shift_data;
  logic                       commit;
  logic [NUM_TAPS*DATA_W-1:0] taps;
  logic                       taps_valid;
  logic [CNT_W-1:0]           shift_count;
  logic                       frame_full;
  logic                       commit_ok;
  logic                       commit_err;
  logic                       overrun;
  // Debug view of the frame state (EMPTY/FILLING/READY/SATURATED)
  logic [1:0]                 frame_state;

  modport master (
    output shift, shift_data, commit,
    input  taps, taps_valid, shift_count, frame_full,
    input  commit_ok, commit_err, overrun, frame_state
  );

  modport slave (
    input  shift, shift_data, commit,
    output taps, taps_valid, shift_count, frame_full,
    output commit_ok, commit_err, overrun, frame_state
  );
endinterface

// File: rtl/servo_frame_shift_reg.sv
// Byte shift chain with double-buffered output taps. Bytes shift in freely;
// the taps seen by the PWM generators only change on an accepted commit so
// every servo updates from one coherent frame. Short frames are rejected and
// shifting past a saturated count is flagged as overrun.
// DEPTH must be >= NUM_TAPS.
module servo_frame_shift_reg #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int NUM_TAPS = 8
) (
  input  logic clk,
  input  logic rst,
  servo_frame_shift_reg_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_TAPS);

  // Frame state is a pure function of shift_count
  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_FILLING   = 2'd1;
  localparam logic [1:0] ST_READY     = 2'd2;
  localparam logic [1:0] ST_SATURATED = 2'd3;

  logic [DATA_W-1:0]          sr [DEPTH];
  logic [NUM_TAPS*DATA_W-1:0] taps_q;
  logic                       taps_valid_q;
  logic [CNT_W-1:0]           count_q;
  logic                       commit_ok_q;
  logic                       commit_err_q;
  logic                       overrun_q;
  logic                       frame_full;
  logic                       accept;
  logic [1:0]                 frame_state;

  assign frame_full = (count_q >= CNT_FULL);
  assign accept     = bus.commit && frame_full;

  // Decode the debug frame state from the fill count
  always_comb begin
    frame_state = ST_EMPTY;
    if (count_q == CNT_MAX) begin
      frame_state = ST_SATURATED;
    end else if (count_q >= CNT_FULL) begin
      frame_state = ST_READY;
    end else if (count_q != '0) begin
      frame_state = ST_FILLING;
    end
  end

  // Live shift chain: moves one stage per shift strobe, last stage drops off
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
    end else if (bus.shift) begin
      sr[0] <= bus.shift_data;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Committed taps: snapshot of the chain as held before the commit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q       <= '0;
      taps_valid_q <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        taps_q[k*DATA_W +: DATA_W] <= sr[k];
      end
      taps_valid_q <= 1'b1;
    end
  end

  // Fill count, overrun flag and commit result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      overrun_q    <= 1'b0;
      commit_ok_q  <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      commit_ok_q  <= accept;
      commit_err_q <= bus.commit && !frame_full;
      if (accept) begin
        // A same-cycle shift starts the next frame
        count_q   <= bus.shift ? CNT_ONE : '0;
        overrun_q <= 1'b0;
      end else if (bus.shift) begin
        if (count_q == CNT_MAX) begin
          overrun_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.taps        = taps_q;
  assign bus.taps_valid  = taps_valid_q;
  assign bus.shift_count = count_q;
  assign bus.frame_full  = frame_full;
  assign bus.commit_ok   = commit_ok_q;
  assign bus.commit_err  = commit_err_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_state = frame_state;
endmodule

// File: tb/tb_servo_frame_shift_reg.sv
// Bench for servo_frame_shift_reg (DATA_W=8, DEPTH=64, NUM_TAPS=8).
// Phase 1: hand-written cycle table with expected outputs.
// Phase 2: random traffic checked against a reference model.
module tb_servo_frame_shift_reg;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 64;
  localparam int NUM_TAPS = 8;
  localparam int W        = 7 + 2 + 1 + 4 + 64;

  typedef struct {
    logic        rs;
    logic        sh;
    logic        cm;
    logic [7:0]  d;
    logic [6:0]  cnt;
    logic        ok;
    logic        err;
    logic        valid;
    logic        ovr;
    logic [63:0] taps;
    string       tag;
  } rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  servo_frame_shift_reg_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_TAPS(NUM_TAPS)) bus ();

  servo_frame_shift_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_TAPS(NUM_TAPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           total = 0;
  int           bad   = 0;
  rec_t         vecs[$];

  function automatic logic [W-1:0] pack_exp(input logic [6:0] cnt, input logic ok, input logic err,
                                            input logic valid, input logic ovr, input logic [63:0] taps);
    logic [1:0] st;
    logic       full;
    full = (cnt >= 7'd8);
    if (cnt == 7'd64)     st = 2'd3;
    else if (cnt >= 7'd8) st = 2'd2;
    else if (cnt != 7'd0) st = 2'd1;
    else                  st = 2'd0;
    return {cnt, st, full, ok, err, valid, ovr, taps};
  endfunction

  function automatic logic [63:0] frame(input logic [7:0] base);
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = base + 8'(7 - k);
    return f;
  endfunction

  task automatic check_out();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        tag;
    got = {bus.shift_count, bus.frame_state, bus.frame_full, bus.commit_ok, bus.commit_err,
           bus.taps_valid, bus.overrun, bus.taps};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%h", got);
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got={cnt,st,full,ok,err,valid,ovr,taps}=%h required=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, input logic s, input logic c, input logic [7:0] d,
                             input logic [W-1:0] e, input string tag);
    @(negedge clk);
    rst            = r;
    bus.shift      = s;
    bus.commit     = c;
    bus.shift_data = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic add(input logic rs, input logic sh, input logic cm, input logic [7:0] d,
                     input logic [6:0] cnt, input logic ok, input logic err, input logic valid,
                     input logic ovr, input logic [63:0] taps, input string tag);
    rec_t r;
    r.rs = rs; r.sh = sh; r.cm = cm; r.d = d;
    r.cnt = cnt; r.ok = ok; r.err = err; r.valid = valid; r.ovr = ovr; r.taps = taps; r.tag = tag;
    vecs.push_back(r);
  endtask

  // n plain shifts of base, base+1, ... starting from count start_cnt (overrun initially 0)
  task automatic add_shifts(input logic [7:0] base, input int n, input int start_cnt,
                            input logic valid, input logic [63:0] taps, input string tag);
    int c;
    for (int i = 0; i < n; i++) begin
      c = start_cnt + i + 1;
      if (c > 64) c = 64;
      add(1'b0, 1'b1, 1'b0, base + 8'(i), 7'(c), 1'b0, 1'b0, valid, (start_cnt + i) >= 64, taps, tag);
    end
  endtask

  // ---------------- reference model for random traffic ----------------
  logic [7:0]  m_sr[64];
  logic [7:0]  m_taps[8];
  logic [6:0]  m_cnt;
  logic        m_valid, m_ovr, m_ok, m_err;

  task automatic model_step(input logic r, input logic s, input logic c, input logic [7:0] d);
    logic acc;
    if (r) begin
      for (int i = 0; i < 64; i++) m_sr[i] = 8'h00;
      for (int k = 0; k < 8; k++) m_taps[k] = 8'h00;
      m_cnt = 0; m_valid = 0; m_ovr = 0; m_ok = 0; m_err = 0;
    end else begin
      acc   = c && (m_cnt >= 7'd8);
      m_ok  = acc;
      m_err = c && !acc;
      if (acc) begin
        for (int k = 0; k < 8; k++) m_taps[k] = m_sr[k];
        m_valid = 1'b1;
        m_ovr   = 1'b0;
        m_cnt   = s ? 7'd1 : 7'd0;
      end else if (s) begin
        if (m_cnt == 7'd64) m_ovr = 1'b1;
        else                m_cnt = m_cnt + 7'd1;
      end
      if (s) begin
        for (int i = 63; i > 0; i--) m_sr[i] = m_sr[i-1];
        m_sr[0] = d;
      end
    end
  endtask

  function automatic logic [63:0] model_taps();
    logic [63:0] t;
    for (int k = 0; k < 8; k++) t[k*8 +: 8] = m_taps[k];
    return t;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [63:0] t;
    logic        r, s, c;
    logic [7:0]  d;
    bus.shift      = 1'b0;
    bus.commit     = 1'b0;
    bus.shift_data = 8'h00;

    // T1: full frame then commit
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 64'h0, "t1_rst");
    add_shifts(8'h10, 8, 0, 1'b0, 64'h0, "t1_fill");
    t = frame(8'h10);
    add(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, t, "t1_commit");
    add(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, t, "t1_idle");
    // T2: short frame rejected
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 64'h0, "t2_rst");
    add_shifts(8'h20, 5, 0, 1'b0, 64'h0, "t2_fill");
    add(0, 0, 1, 8'h00, 5, 0, 1, 0, 0, 64'h0, "t2_short");
    add(0, 0, 0, 8'h00, 5, 0, 0, 0, 0, 64'h0, "t2_idle");
    // T3: commit on the 8th shift is judged on the old count
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 64'h0, "t3_rst");
    add_shifts(8'h30, 7, 0, 1'b0, 64'h0, "t3_fill");
    add(0, 1, 1, 8'h37, 8, 0, 1, 0, 0, 64'h0, "t3_race");
    t = frame(8'h30);
    add(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, t, "t3_commit");
    // T4: commit + shift in the same cycle excludes the new word
    add_shifts(8'hA0, 8, 0, 1'b1, t, "t4_fill");
    t = frame(8'hA0);
    add(0, 1, 1, 8'hFF, 1, 1, 0, 1, 0, t, "t4_commit_shift");
    add(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, t, "t4_idle");
    // Commit held high: accepted once, then rejected on the emptied count
    add_shifts(8'h50, 8, 1, 1'b1, t, "hold_fill");
    t = frame(8'h50);
    add(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, t, "hold_commit1");
    add(0, 0, 1, 8'h00, 0, 0, 1, 1, 0, t, "hold_commit2");
    add(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, t, "hold_release");
    // T5: saturation and overrun, cleared by commit
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 64'h0, "t5_rst");
    add_shifts(8'h00, 65, 0, 1'b0, 64'h0, "t5_fill");
    t = frame(8'h39);
    add(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, t, "t5_commit");
    // T6: reset mid-frame with shift and commit also asserted
    add_shifts(8'h60, 3, 0, 1'b1, t, "t6_fill");
    add(1, 1, 1, 8'h77, 0, 0, 0, 0, 0, 64'h0, "t6_rst");
    add(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 64'h0, "t6_idle");

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rs, vecs[i].sh, vecs[i].cm, vecs[i].d,
                  pack_exp(vecs[i].cnt, vecs[i].ok, vecs[i].err, vecs[i].valid, vecs[i].ovr, vecs[i].taps),
                  vecs[i].tag);
    end

    // Random traffic against the model; early stretch commits rarely to reach saturation
    model_step(1'b1, 1'b0, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00,
                pack_exp(m_cnt, m_ok, m_err, m_valid, m_ovr, model_taps()), "rand_rst");
    for (int n = 0; n < 500; n++) begin
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 3) != 0);
      c = (n < 150) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 5) == 0);
      d = 8'($urandom_range(0, 255));
      model_step(r, s, c, d);
      drive_cycle(r, s, c, d, pack_exp(m_cnt, m_ok, m_err, m_valid, m_ovr, model_taps()), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
